// File: rtl/i2c_target_responder_pkg.sv
// Shared definitions for the I2C target responder: FSM states, bus bit
// values and byte geometry.
package i2c_target_responder_pkg;

  localparam int   BYTE_BITS = 8;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

  // True when the bit counter marks the last bit of a byte.
  function automatic logic is_last_bit(input logic [3:0] cnt);
    return cnt == 4'(BYTE_BITS - 1);
  endfunction

endpackage

// File: rtl/i2c_target_responder_if.sv
// Bus pins plus the byte-wide register access port of the I2C target.
interface i2c_target_responder_if #(
  parameter int PTR_W = 8
);

  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_wr;
  logic             reg_rd;
  logic [7:0]       reg_rdata;
  logic             busy;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Oversampling front end for an I2C bus: 2-FF synchronizers on SCL/SDA and
// single-clk SCL edge and START/STOP condition pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_prev;
  logic       sda_prev;

  // Cleared to 1 (idle bus level) so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff   <= 2'b11;
      sda_ff   <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value and the
      // chain shifts one stage per clock regardless of statement order.
      scl_ff   <= {scl_ff[0], scl_in};
      sda_ff   <= {sda_ff[0], sda_in};
      scl_prev <= scl_ff[1];
      sda_prev <= sda_ff[1];
    end
  end

  assign sda      = sda_ff[1];
  assign scl_rise =  scl_ff[1] & ~scl_prev;
  assign scl_fall = ~scl_ff[1] &  scl_prev;
  assign start    =  scl_ff[1] &  scl_prev &  sda_prev & ~sda_ff[1];
  assign stop     =  scl_ff[1] &  scl_prev & ~sda_prev &  sda_ff[1];

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target answering at DEV_ADDR: register pointer, byte writes and
// pointer-auto-incrementing reads through a local register port.
module i2c_target_responder
  import i2c_target_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h49,
  parameter int         PTR_W    = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  i2c_target_responder_if.slave  bus
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  i2c_state_e       state_q,     state_d;
  logic [3:0]       bit_cnt_q,   bit_cnt_d;
  logic             bit_seen_q,  bit_seen_d;
  logic [7:0]       rx_q,        rx_d;
  logic [7:0]       tx_q,        tx_d;
  logic             rw_q,        rw_d;
  logic             ack_ok_q,    ack_ok_d;
  logic             rd_dly_q,    rd_dly_d;
  logic             sda_oe_q,    sda_oe_d;
  logic [PTR_W-1:0] reg_addr_q,  reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             reg_wr_q,    reg_wr_d;
  logic             reg_rd_q,    reg_rd_d;
  logic             busy_q,      busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_seen_q  <= 1'b0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      ack_ok_q    <= 1'b0;
      rd_dly_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_seen_q  <= bit_seen_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      ack_ok_q    <= ack_ok_d;
      rd_dly_q    <= rd_dly_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every next-value starts as a hold (or zero for strobes) so no
    // path through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_seen_d  = bit_seen_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    ack_ok_d    = ack_ok_q;
    rd_dly_d    = reg_rd_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    busy_d      = busy_q;

    // Post-write pointer bump and read-data capture run beside the FSM.
    if (reg_wr_q) reg_addr_d = reg_addr_q + PTR_W'(1);
    if (rd_dly_q) tx_d = bus.reg_rdata;

    if (bus_start) begin
      state_d    = ADDR;
      busy_d     = 1'b1;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = '0;
      bit_seen_d = 1'b0;
      ack_ok_d   = 1'b0;
    end else if (bus_stop) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = '0;
      bit_seen_d = 1'b0;
      ack_ok_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            rx_d       = {rx_q[6:0], sda_s};
            bit_seen_d = 1'b1;
          end else if (scl_fall && bit_seen_q) begin
            bit_seen_d = 1'b0;
            if (!is_last_bit(bit_cnt_q)) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              bit_cnt_d = '0;
              if (state_q == ADDR) begin
                if (rx_q[7:1] == DEV_ADDR) begin
                  state_d  = ADDR_ACK;
                  sda_oe_d = 1'b1;
                  rw_d     = rx_q[0];
                  reg_rd_d = rx_q[0];
                end else begin
                  state_d  = IGNORE;
                end
              end else if (state_q == PTR) begin
                state_d    = PTR_ACK;
                sda_oe_d   = 1'b1;
                reg_addr_d = PTR_W'(rx_q);
              end else begin
                state_d     = WDATA_ACK;
                sda_oe_d    = 1'b1;
                reg_wdata_d = rx_q;
                reg_wr_d    = 1'b1;
              end
            end
          end
        end

        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt_d  = '0;
            bit_seen_d = 1'b0;
            if (rw_q) begin
              state_d  = RDATA;
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b1};
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_seen_d = 1'b1;
          end else if (scl_fall && bit_seen_q) begin
            bit_seen_d = 1'b0;
            if (is_last_bit(bit_cnt_q)) begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              ack_ok_d  = 1'b0;
              state_d   = RDATA_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b1};
            end
          end
        end

        RDATA_ACK: begin
          // Master ACK prefetches the next byte during the ACK high phase.
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ack_ok_d   = 1'b1;
              reg_addr_d = reg_addr_q + PTR_W'(1);
              reg_rd_d   = 1'b1;
            end else if (sda_s == I2C_NACK) begin
              state_d    = IGNORE;
            end
          end else if (scl_fall && ack_ok_q) begin
            ack_ok_d = 1'b0;
            state_d  = RDATA;
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b1};
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.busy      = busy_q;

  a_wr_rd_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(reg_wr_q && reg_rd_q)
  );

endmodule
